// File: rtl/movegen_sequencer_if.sv
// movegen_sequencer_if: position stream, array strobe/response and move-record
// signals shared between the sequencer (slave) and its environment (master).
interface movegen_sequencer_if #(parameter int CNTW = 8);
    logic            start;
    logic            wtp;
    logic            abort;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_data;
    logic            pos_valid;
    logic [3:0]      pos_data;
    logic            wtp_out;
    logic [63:0]     emit_move;
    logic [63:0]     target_square;
    logic            mv_valid;
    logic            mv_ready;
    logic [5:0]      mv_from;
    logic [5:0]      mv_to;
    logic [CNTW-1:0] mv_count;
    logic            busy;
    logic            done;
    modport slave (
        input  start, wtp, abort, in_valid, in_data, target_square, mv_ready,
        output in_ready, pos_valid, pos_data, wtp_out, emit_move,
               mv_valid, mv_from, mv_to, mv_count, busy, done
    );
    modport master (
        output start, wtp, abort, in_valid, in_data, target_square, mv_ready,
        input  in_ready, pos_valid, pos_data, wtp_out, emit_move,
               mv_valid, mv_from, mv_to, mv_count, busy, done
    );
endinterface

// File: rtl/movegen_sequencer.sv
// movegen_sequencer: streams a position into the square chain, strobes each
// square of the side to move and drains its target flags as (from, to) records.
module movegen_sequencer #(
    parameter int NSQ  = 64,
    parameter int CNTW = 8
) (
    input logic                clk,
    input logic                rst_n,
    movegen_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_EMIT, S_DRAIN, S_DONE} state_t;
    state_t          r_state, w_next;
    logic            r_wtp;
    logic [NSQ-1:0]  r_own, r_tgt;
    logic [5:0]      r_ld, r_src;
    logic [CNTW-1:0] r_cnt;
    logic            w_acc, w_last_tgt, w_take;

    function automatic logic [5:0] lowest(input logic [NSQ-1:0] v);
        lowest = '0;
        for (int i = NSQ - 1; i >= 0; i--) if (v[i]) lowest = 6'(i);
    endfunction

    assign w_acc      = bus.in_valid && r_state == S_LOAD;
    assign w_take     = r_state == S_DRAIN && bus.mv_ready;
    assign w_last_tgt = (r_tgt & (r_tgt - NSQ'(1))) == '0;

    assign bus.in_ready  = r_state == S_LOAD;
    assign bus.pos_valid = w_acc;
    assign bus.pos_data  = bus.in_data;
    assign bus.wtp_out   = r_wtp;
    assign bus.emit_move = r_state == S_EMIT ? NSQ'(1) << r_src : '0;
    assign bus.mv_valid  = r_state == S_DRAIN;
    assign bus.mv_from   = r_src;
    assign bus.mv_to     = lowest(r_tgt);
    assign bus.mv_count  = r_cnt;
    assign bus.busy      = r_state != S_IDLE;
    assign bus.done      = r_state == S_DONE;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = bus.start ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = w_acc && r_ld == 6'd63 ? S_SCAN : S_LOAD;
            S_SCAN:  w_next = r_own == '0 ? S_DONE : S_EMIT;
            S_EMIT:  w_next = bus.target_square == '0 ? S_SCAN : S_DRAIN;
            S_DRAIN: w_next = bus.mv_ready && w_last_tgt ? S_SCAN : S_DRAIN;
            default: w_next = S_IDLE;
        endcase
        if (bus.abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wtp   <= 1'b0;
            r_own   <= '0;
            r_tgt   <= '0;
            r_ld    <= '0;
            r_src   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.start && !bus.abort) begin
                r_wtp <= bus.wtp;
                r_own <= '0;
                r_cnt <= '0;
                r_ld  <= '0;
            end
            // nibble n lands on square 63-n, i.e. index ~n
            if (w_acc) begin
                r_own[~r_ld] <= bus.in_data[2:0] != 3'd0 && bus.in_data[3] == r_wtp;
                r_ld         <= r_ld + 6'd1;
            end
            if (r_state == S_SCAN) r_src <= lowest(r_own);
            if (r_state == S_EMIT) begin
                r_tgt        <= bus.target_square;
                r_own[r_src] <= 1'b0;
            end
            if (w_take) begin
                r_tgt <= r_tgt & (r_tgt - NSQ'(1));
                if (r_cnt != '1) r_cnt <= r_cnt + CNTW'(1);
            end
            if (bus.abort) r_tgt <= '0;
        end
    end
endmodule
